mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide execution unit; consumes the 4-bit ALU control code produced by ALUControl.
//  Accepts mult (4'b0101) and div (4'b1011) and writes a HI/LO result pair.
//  Sits beside the single-cycle ALU; the pipeline/stall logic holds the core while busy is high.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  alu_control  in   4      operation code; only 4'b0101 (mult) and 4'b1011 (div) are acted on
//  start        in   1      request; sampled only in IDLE
//  op_a         in   WIDTH  multiplicand / dividend; captured on accepted start
//  op_b         in   WIDTH  multiplier / divisor; captured on accepted start
//  busy         out  1      high while state != IDLE
//  done         out  1      one-cycle pulse; HI/LO are valid from this cycle onward
//  hi           out  WIDTH  mult: upper product half; div: remainder
//  lo           out  WIDTH  mult: lower product half; div: quotient
//  div_by_zero  out  1      set with done on a div whose op_b==0; cleared on the next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, div_by_zero=0; hi=lo=0; counter and operand regs=0.
//  FSM: IDLE -> MUL | DIV -> FIN -> IDLE.
//  Accept: in IDLE with start=1 and alu_control in {0101,1011}; otherwise start is ignored.
//   Operands are latched and counter=WIDTH.
//  start while busy (MUL/DIV/FIN) is ignored; it is not queued.
//  MUL: radix-2 shift-add over the 2*WIDTH accumulator.
//   One iteration per cycle; counter decrements; at 0 -> FIN.
//  DIV: restoring division, one quotient bit per cycle; at counter 0 -> FIN.
//   If op_b==0 at accept: go directly to FIN next cycle with hi=op_a, lo={WIDTH{1'b1}}, div_by_zero=1.
//  FIN: hi/lo/div_by_zero written on the entering edge; done=1 for exactly this cycle; -> IDLE.
//  Latency: accept edge E; done high in cycle E+WIDTH+1 (divide-by-zero: E+1).
//   busy is high from E to the end of FIN.
//  hi/lo hold their previous result until the next FIN; they never show intermediate values.
//  Multiply result is a full 2*WIDTH product with no overflow.
//  Division truncates toward zero: remainder = dividend - quotient*divisor.
//  rst_n asserted mid-operation aborts immediately with full reset values; no done pulse.
// CONFIGURATION
//  MDU_SIGNED_EN defined:
//   - Operands are two's complement; magnitudes are taken at accept.
//   - Product and quotient are negated in FIN when sign(a)^sign(b) is set.
//   - Remainder takes the sign of the dividend.
//   - Overflow case min/-1 gives lo=min, hi=0, div_by_zero=0.
//   - Latency is unchanged; sign fix-up is done combinationally into the FIN write.
//  MDU_SIGNED_EN undefined: all operands and results are unsigned; no sign logic is present.
// STRUCTURE
//  Package mdu_pkg:
//   - ALU_CTRL_MULT=4'b0101 and ALU_CTRL_DIV=4'b1011; these codes are shared with ALUControl.
//   - State enum IDLE/MUL/DIV/FIN.
//  Sub-module mdu_div_step (combinational):
//   - Inputs: partial remainder, divisor, dividend bit.
//   - Outputs: next remainder and quotient bit.
//   - Instantiated once, used on every DIV cycle.
//  Iteration control, accumulator, counter and FSM live in mult_div_unit.
// TESTING (WIDTH=32)
//  mult 7 x 6:
//   -> done at E+33; hi=0, lo=42; busy is high for 34 cycles.
//  mult FFFFFFFF x FFFFFFFF (unsigned):
//   -> hi=FFFFFFFE, lo=00000001.
//  div 100 / 7:
//   -> lo=14, hi=2, div_by_zero=0.
//  div 5 / 0:
//   -> done at E+1; hi=5, lo=FFFFFFFF, div_by_zero=1.
//   -> Next accepted start clears div_by_zero.
//  start pulsed with alu_control=0010, and again while busy:
//   -> no state change; hi/lo unchanged; no extra done.
//  rst_n low at E+10 during a mult:
//   -> busy=0, hi=lo=0 immediately, no done.
//   -> A fresh mult after release completes normally.
//  MDU_SIGNED_EN, div -7 / 2:
//   -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1).
//  MDU_SIGNED_EN, 80000000 / FFFFFFFF:
//   -> lo=80000000, hi=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit (package mdu_pkg).
// The ALU control codes are the same ones ALUControl produces.
package mdu_pkg;

  localparam logic [3:0] ALU_CTRL_MULT = 4'b0101;
  localparam logic [3:0] ALU_CTRL_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);

  logic [3:0]       alu_control;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output alu_control, start, op_a, op_b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  alu_control, start, op_a, op_b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; restore (keep the shifted value) when it would go negative.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    if (shifted_s >= {1'b0, divisor}) begin
      rem_out = diff_s[WIDTH-1:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit producing a HI/LO result pair.
// Optional feature macro: MDU_SIGNED_EN (two's complement operands/results).
// Accumulator layout: mult {partial product, remaining multiplier bits};
// div {partial remainder, dividend bits shifting out / quotient bits shifting in}.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  mdu_state_e         state_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               dz_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
`ifdef MDU_SIGNED_EN
  logic               neg_q_r;
  logic               neg_r_r;
`endif

  logic               is_mult_s;
  logic               is_div_s;
  logic               accept_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic               q_bit_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;

  // Decode the request and form operand magnitudes for the iteration datapath.
  always_comb begin
    is_mult_s = (bus.alu_control == ALU_CTRL_MULT);
    is_div_s  = (bus.alu_control == ALU_CTRL_DIV);
    accept_s  = (state_r == IDLE) && bus.start && (is_mult_s || is_div_s);
`ifdef MDU_SIGNED_EN
    if (bus.op_a[WIDTH-1]) begin
      mag_a_s = ~bus.op_a + 1'b1;
    end else begin
      mag_a_s = bus.op_a;
    end
    if (bus.op_b[WIDTH-1]) begin
      mag_b_s = ~bus.op_b + 1'b1;
    end else begin
      mag_b_s = bus.op_b;
    end
`else
    mag_a_s = bus.op_a;
    mag_b_s = bus.op_b;
`endif
  end

  // Shift-add step: add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    if (acc_r[0]) begin
      add_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      add_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in      (acc_r[2*WIDTH-1:WIDTH]),
    .divisor     (opnd_r),
    .dividend_bit(acc_r[WIDTH-1]),
    .rem_out     (rem_next_s),
    .q_bit       (q_bit_s)
  );

  // Final HI/LO values written on the edge entering FIN (sign fix-up when enabled).
  always_comb begin
    fin_hi_s = acc_r[2*WIDTH-1:WIDTH];
    fin_lo_s = acc_r[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
    if (!dz_r && (state_r == MUL) && neg_q_r) begin
      {fin_hi_s, fin_lo_s} = ~acc_r + 1'b1;
    end else if (!dz_r && (state_r == DIV)) begin
      if (neg_q_r) begin
        fin_lo_s = ~acc_r[WIDTH-1:0] + 1'b1;
      end else begin
        fin_lo_s = acc_r[WIDTH-1:0];
      end
      if (neg_r_r) begin
        fin_hi_s = ~acc_r[2*WIDTH-1:WIDTH] + 1'b1;
      end else begin
        fin_hi_s = acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      fin_hi_s = acc_r[2*WIDTH-1:WIDTH];
      fin_lo_s = acc_r[WIDTH-1:0];
    end
`endif
  end

  // Control FSM with iteration counter, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      dz_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
`ifdef MDU_SIGNED_EN
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy_r <= 1'b1;
            dbz_r  <= 1'b0;
            cnt_r  <= CNT_INIT;
`ifdef MDU_SIGNED_EN
            neg_q_r <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            neg_r_r <= bus.op_a[WIDTH-1];
`endif
            if (is_mult_s) begin
              state_r <= MUL;
              acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
              opnd_r  <= mag_a_s;
              dz_r    <= 1'b0;
            end else if (bus.op_b == {WIDTH{1'b0}}) begin
              // Divide by zero: result preloaded, FIN follows on the next edge.
              state_r <= DIV;
              acc_r   <= {bus.op_a, {WIDTH{1'b1}}};
              opnd_r  <= {WIDTH{1'b0}};
              dz_r    <= 1'b1;
            end else begin
              state_r <= DIV;
              acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
              opnd_r  <= mag_b_s;
              dz_r    <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIN;
            hi_r    <= fin_hi_s;
            lo_r    <= fin_lo_s;
            dbz_r   <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            acc_r <= {add_s, acc_r[WIDTH-1:1]};
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DIV: begin
          if (dz_r || (cnt_r == {CW{1'b0}})) begin
            state_r <= FIN;
            hi_r    <= fin_hi_s;
            lo_r    <= fin_lo_s;
            dbz_r   <= dz_r;
            done_r  <= 1'b1;
          end else begin
            acc_r <= {rem_next_s, acc_r[WIDTH-2:0], q_bit_s};
            cnt_r <= cnt_r - 1'b1;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int  W = 32;
  localparam time P = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    time          t_done;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition.
  function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input time te);
    exp_t e;
    logic [63:0] p;
`ifdef MDU_SIGNED_EN
    longint sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`endif
    e.dbz = 1'b0;
    e.t_done = te + (W + 1) * P + P / 2;
    if (code == ALU_CTRL_MULT) begin
`ifdef MDU_SIGNED_EN
      sq = sa * sb;
      p = sq;
`else
      p = {32'h0, a} * {32'h0, b};
`endif
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dbz = 1'b1;
      e.t_done = te + P + P / 2;
    end else begin
`ifdef MDU_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        e.lo = sq[31:0];
        e.hi = sr[31:0];
      end
`else
      e.lo = a / b;
      e.hi = a % b;
`endif
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done at time %0t hi=%0h lo=%0h", $time, bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi", 64'(bus.hi), 64'(e.hi));
        check("lo", 64'(bus.lo), 64'(e.lo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        check("done_time", 64'($time), 64'(e.t_done));
      end
    end
  end

  task automatic issue(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_accept);
    exp_t e;
    @(negedge clk);
    bus.alu_control = code;
    bus.start = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    if (expect_accept) begin
      e = model(code, a, b, $time);
      sb_q.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    #1 bus.start = 1'b0;
  endtask

  // Count busy cycles until idle; exp_busy < 0 only waits.
  task automatic wait_idle(input string name, input int exp_busy);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check({name, "_timeout"}, 64'(n), 64'(0));
    else if (exp_busy >= 0) check(name, 64'(n), 64'(exp_busy));
  endtask

  task automatic run_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(code, a, b, 1'b1);
    wait_idle("busy_len", (code == ALU_CTRL_DIV && b == '0) ? 2 : W + 2);
  endtask

  initial begin
    bus.alu_control = 4'b0000;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(ALU_CTRL_MULT, 32'd7, 32'd6);
    run_op(ALU_CTRL_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_CTRL_DIV, 32'd100, 32'd7);
    run_op(ALU_CTRL_DIV, 32'd5, 32'd0);
    check("dbz_held", 64'(bus.div_by_zero), 64'(1));
    issue(ALU_CTRL_MULT, 32'd3, 32'd4, 1'b1);
    check("dbz_clear_on_accept", 64'(bus.div_by_zero), 64'(0));
    wait_idle("busy_len", W + 2);

    // Unsupported code: nothing moves.
    issue(4'b0010, 32'd9, 32'd9, 1'b0);
    check("bad_code_busy", 64'(bus.busy), 64'(0));
    check("bad_code_hi", 64'(bus.hi), 64'(last_hi));
    check("bad_code_lo", 64'(bus.lo), 64'(last_lo));

    // Start while busy is ignored; only one done follows.
    issue(ALU_CTRL_MULT, 32'd9, 32'd11, 1'b1);
    repeat (5) @(negedge clk);
    bus.alu_control = ALU_CTRL_DIV;
    bus.op_a = 32'd77;
    bus.op_b = 32'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_during_op", 64'(bus.busy), 64'(1));
    wait_idle("busy_tail", -1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a multiply.
    issue(ALU_CTRL_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_hi", 64'(bus.hi), 64'(0));
    check("abort_lo", 64'(bus.lo), 64'(0));
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ALU_CTRL_MULT, 32'd1000, 32'd1000);

`ifdef MDU_SIGNED_EN
    run_op(ALU_CTRL_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(ALU_CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_CTRL_MULT, 32'hFFFF_FFFD, 32'd5);
`endif

    // Randomized mix of operations.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   code;
      logic [W-1:0] a, b;
      int           sel;
      code = ($urandom_range(1) == 0) ? ALU_CTRL_MULT : ALU_CTRL_DIV;
      a = $urandom;
      sel = $urandom_range(7);
      if (sel == 0) b = '0;
      else if (sel < 4) b = W'($urandom_range(1000));
      else b = $urandom;
      run_op(code, a, b);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
